// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_if
// Brief    : Enqueue/dequeue handshake and status bundle for sync_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    logic                     enq_en;
    logic [WIDTH-1:0]         enq_data;
    logic                     deq_en;
    logic [WIDTH-1:0]         deq_data;
    logic                     empty;
    logic                     almost_empty;
    logic                     almost_full;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output enq_en, enq_data, deq_en,
        input  deq_data, empty, almost_empty, almost_full, full, count,
               overflow, underflow
    );

    modport slave (
        input  enq_en, enq_data, deq_en,
        output deq_data, empty, almost_empty, almost_full, full, count,
               overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO with watermark flags.
//            Define SYNC_FIFO_ERR_EN to build sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int ALMOST_FULL  = 3,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);
    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_LEVEL = c_CNT_W'(DEPTH - ALMOST_FULL);
    localparam logic [c_CNT_W-1:0] c_AE_LEVEL = c_CNT_W'(ALMOST_EMPTY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_head;

    logic w_empty;
    logic w_full;
    logic w_enq_ok;
    logic w_deq_ok;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_enq_ok = bus.enq_en & ~w_full;
    assign w_deq_ok = bus.deq_en & ~w_empty;

    // Storage is not cleared on reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_enq_ok) begin
            r_mem[r_wr_ptr] <= bus.enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_enq_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_deq_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_enq_ok, w_deq_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // r_head shadows r_mem[r_rd_ptr]; bypass the write data when the
            // incoming word becomes the head in the same cycle.
            if (w_deq_ok) begin
                if (r_count > c_CNT_ONE) begin
                    r_head <= r_mem[r_rd_ptr + c_PTR_ONE];
                end else if (w_enq_ok) begin
                    r_head <= bus.enq_data;
                end
            end else if (w_enq_ok && w_empty) begin
                r_head <= bus.enq_data;
            end
        end
    end

    assign bus.deq_data     = r_head;
    assign bus.count        = r_count;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_count >= c_AF_LEVEL);
    assign bus.almost_empty = (r_count <= c_AE_LEVEL);

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.enq_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.deq_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Self-checking bench for sync_fifo (DEPTH=8, AF=2, AE=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 8;
    localparam int c_AF    = 2;
    localparam int c_AE    = 1;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    sync_fifo_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) bus ();

    sync_fifo #(
        .WIDTH        (c_WIDTH),
        .DEPTH        (c_DEPTH),
        .ALMOST_FULL  (c_AF),
        .ALMOST_EMPTY (c_AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       enq;
        logic       deq;
        logic [7:0] data;
        int         exp_count;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_af;
        logic       exp_ae;
        logic [7:0] exp_head;
    } vec_t;

    vec_t       tbl [19];
    logic [7:0] sbq [$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = sbq.size();
        chk("count",        32'(bus.count),        32'(n));
        chk("empty",        32'(bus.empty),        32'(n == 0));
        chk("full",         32'(bus.full),         32'(n == c_DEPTH));
        chk("almost_full",  32'(bus.almost_full),  32'(n >= c_DEPTH - c_AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= c_AE));
        if (n > 0) chk("head", 32'(bus.deq_data), 32'(sbq[0]));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_unf));
    endtask

    // One clock: drive, clock, update scoreboard from pre-edge state, compare.
    task automatic step(input logic r, input logic e, input logic [7:0] d, input logic q);
        int         n;
        logic [7:0] pre_head;
        logic [7:0] popped;
        n        = sbq.size();
        pre_head = bus.deq_data;
        rst = r; bus.enq_en = e; bus.enq_data = d; bus.deq_en = q;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.enq_en = 1'b0; bus.deq_en = 1'b0;
        if (r) begin
            sbq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
`ifdef SYNC_FIFO_ERR_EN
            if (e && n == c_DEPTH) m_ovf = 1'b1;
            if (q && n == 0)       m_unf = 1'b1;
`endif
            if (q && n > 0) begin
                popped = sbq.pop_front();
                chk("deq_data", 32'(pre_head), 32'(popped));
            end
            if (e && n < c_DEPTH) sbq.push_back(d);
        end
        check_model();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_count"},     32'(bus.count),        32'(0));
        chk({tag, "_empty"},     32'(bus.empty),        32'(1));
        chk({tag, "_full"},      32'(bus.full),         32'(0));
        chk({tag, "_ae"},        32'(bus.almost_empty), 32'(1));
        chk({tag, "_af"},        32'(bus.almost_full),  32'(0));
        chk({tag, "_data"},      32'(bus.deq_data),     32'(0));
        chk({tag, "_overflow"},  32'(bus.overflow),     32'(0));
        chk({tag, "_underflow"}, 32'(bus.underflow),    32'(0));
    endtask

    initial begin
        int   sent;
        int   got;
        int   cyc;
        int   n;
        logic e;
        logic q;

        // Fill 1..8, collide at full, drain, then empty-side corner cases.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{enq: 1'b1, deq: 1'b0, data: 8'(i + 1), exp_count: i + 1,
                       exp_empty: 1'b0, exp_full: (i == 7), exp_af: ((i + 1) >= 6),
                       exp_ae: ((i + 1) <= 1), exp_head: 8'h01};
        end
        tbl[8] = '{1'b1, 1'b1, 8'h99, 7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02};
        for (int i = 0; i < 7; i++) begin
            tbl[9 + i] = '{enq: 1'b0, deq: 1'b1, data: 8'h00, exp_count: 6 - i,
                           exp_empty: ((6 - i) == 0), exp_full: 1'b0,
                           exp_af: ((6 - i) >= 6), exp_ae: ((6 - i) <= 1),
                           exp_head: 8'(3 + i)};
        end
        tbl[16] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[17] = '{1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[18] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};

        rst = 1'b1; bus.enq_en = 1'b0; bus.deq_en = 1'b0; bus.enq_data = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        reset_check("init");

        for (int k = 0; k < 19; k++) begin
            step(1'b0, tbl[k].enq, tbl[k].data, tbl[k].deq);
            chk("tbl_count", 32'(bus.count),        32'(tbl[k].exp_count));
            chk("tbl_empty", 32'(bus.empty),        32'(tbl[k].exp_empty));
            chk("tbl_full",  32'(bus.full),         32'(tbl[k].exp_full));
            chk("tbl_af",    32'(bus.almost_full),  32'(tbl[k].exp_af));
            chk("tbl_ae",    32'(bus.almost_empty), 32'(tbl[k].exp_ae));
            if (!tbl[k].exp_empty) chk("tbl_head", 32'(bus.deq_data), 32'(tbl[k].exp_head));
        end

        // Fall-through latency from a freshly reset FIFO.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("fwft_data",  32'(bus.deq_data), 32'(8'hA5));
        chk("fwft_count", 32'(bus.count),    32'(1));
        chk("fwft_empty", 32'(bus.empty),    32'(0));

        // Reset at count=5 with both requests asserted.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'(5));
        step(1'b1, 1'b1, 8'h77, 1'b1);
        reset_check("midrst");
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("post_rst_head", 32'(bus.deq_data), 32'(8'h3C));
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random streaming of 3*DEPTH words across pointer wrap.
        sent = 0; got = 0; cyc = 0;
        while (got < 3 * c_DEPTH && cyc < 2000) begin
            n = sbq.size();
            e = (sent < 3 * c_DEPTH) && ($urandom_range(0, 1) == 1);
            q = ($urandom_range(0, 1) == 1);
            if (q && n > 0)       got++;
            if (e && n < c_DEPTH) sent++;
            step(1'b0, e, 8'($urandom), q);
            chk("count_bound", 32'(bus.count <= c_DEPTH), 32'(1));
            cyc++;
        end
        chk("stream_done", 32'(got), 32'(3 * c_DEPTH));
        chk("stream_empty", 32'(bus.empty), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data word width in bits, 1 or more.
REQ-002 The block SHALL have parameter DEPTH, default 32: capacity in words, a power of two, 2 or more.
REQ-003 The block SHALL have parameter ALMOST_FULL, default 3: almost_full asserts when count >= DEPTH-ALMOST_FULL, with 0 <= ALMOST_FULL < DEPTH.
REQ-004 The block SHALL have parameter ALMOST_EMPTY, default 1: almost_empty asserts when count <= ALMOST_EMPTY, with 0 <= ALMOST_EMPTY < DEPTH.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous active-high reset
  enq_en  in  1  enqueue request
  enq_data  in  WIDTH  enqueue word
  deq_en  in  1  dequeue request; acknowledges the current deq_data
  deq_data  out  WIDTH  head word, first-word-fall-through
  empty  out  1  no valid head word
  almost_empty  out  1  low-watermark flag
  almost_full  out  1  high-watermark flag
  full  out  1  count == DEPTH
  count  out  $clog2(DEPTH)+1  occupancy
  overflow  out  1  sticky: enqueue was attempted while full
  underflow  out  1  sticky: dequeue was attempted while empty

Function
REQ-006 The block SHALL accept an enqueue at a rising edge only when enq_en=1 and full=0, sampling full before the edge.
REQ-007 The block SHALL accept a dequeue at a rising edge only when deq_en=1 and empty=0, sampling empty before the edge.
REQ-008 The block SHALL ignore rejected requests: storage, pointers and count are unchanged.
REQ-009 The block SHALL be first-word-fall-through: a word enqueued into an empty FIFO at edge N appears on deq_data with empty=0 from edge N+1.
REQ-010 After an accepted dequeue at edge N, the block SHALL present the next word on deq_data from edge N+1, or assert empty if no word remains.
REQ-011 The block SHALL hold deq_data stable while empty=0 and no dequeue is accepted.
REQ-012 count SHALL equal accepted enqueues minus accepted dequeues, including the word held in the output stage, and SHALL update at the edge where a request is accepted.
REQ-013 count SHALL stay in the range 0..DEPTH, and full SHALL be 1 exactly when count == DEPTH.
REQ-014 The block SHALL derive empty, full, almost_empty and almost_full from registered state only, with no combinational path from enq_en or deq_en.
REQ-015 On a simultaneous enqueue and dequeue with 0 < count < DEPTH, the block SHALL accept both and leave count unchanged.
REQ-016 On a simultaneous enqueue and dequeue while full, the block SHALL accept the dequeue and reject the enqueue, so count becomes DEPTH-1.
REQ-017 On a simultaneous enqueue and dequeue while empty, the block SHALL accept the enqueue and reject the dequeue, so count becomes 1.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated words across the wrap.
REQ-019 Output order SHALL equal input order for every accepted word.

Reset
REQ-020 When rst=1 at a rising edge, the block SHALL clear pointers and count and discard all stored words, including during active traffic.
REQ-021 After reset the outputs SHALL be: empty=1, full=0, almost_empty=1, almost_full=0, count=0, deq_data=0, overflow=0, underflow=0.
REQ-022 The block SHALL ignore enq_en and deq_en in any cycle where rst=1.

Configuration
REQ-023 Macro SYNC_FIFO_ERR_EN SHALL control error detection.
REQ-024 With SYNC_FIFO_ERR_EN defined, overflow SHALL set to 1 at the edge after enq_en=1 with full=1, and underflow SHALL set to 1 at the edge after deq_en=1 with empty=1.
REQ-025 With SYNC_FIFO_ERR_EN defined, overflow and underflow SHALL clear only on rst.
REQ-026 Without SYNC_FIFO_ERR_EN, the overflow and underflow ports SHALL remain present and be tied to 0, and no detection logic SHALL be built.

Verification
REQ-027 Fill and drain, DEPTH=8, ALMOST_FULL=2, ALMOST_EMPTY=1: enqueue 0x1..0x8 on consecutive cycles -> almost_full=1 once count reaches 6, full=1 at count 8; dequeue all -> 0x1..0x8 in order, then empty=1 and count=0.
REQ-028 Fall-through latency: enqueue 0xA5 into an empty FIFO at edge N -> deq_data=0xA5 and empty=0 after edge N+1, with count=1.
REQ-029 Full-boundary collision: with count=8, DEPTH=8, assert enq_en and deq_en together -> count=7, the head word advances, the new word is dropped, and overflow=1 when SYNC_FIFO_ERR_EN is defined.
REQ-030 Wrap and streaming: run 3*DEPTH words with random enq_en/deq_en at 50% each -> a scoreboard sees an exact in-order match and count never exceeds DEPTH.
REQ-031 Mid-traffic reset: pulse rst for 1 cycle with count=5 -> all reset values of REQ-021 hold the next cycle; enqueue 0x3C afterwards -> it is the next word out.
REQ-032 Underflow: assert deq_en while empty -> count stays 0; underflow=1 with SYNC_FIFO_ERR_EN defined, 0 without it.
